// File: rtl/seg7_hex_scan.sv
// seg7_hex_scan: captures 4-bit hex values into a short history buffer
// (newest in entry 0) and time-multiplexes the buffer onto a
// common-cathode seven-segment array. Digit 0 is the rightmost digit.
// Optional feature macro: SEG7_LZB_EN (leading-zero blanking on digits >= 1).
module seg7_hex_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic [3:0]        din,
  input  logic              din_vld,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              full
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = $clog2(DIGITS + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Hex digit to {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [3:0]        hbuf_r [DIGITS];
  logic [FW-1:0]     fill_r;
  logic [PW-1:0]     pre_r;
  logic [IW-1:0]     idx_r;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;
  logic              full_r;

  logic [3:0]        cur_s;
  logic [DIGITS-1:0] an_s;
  logic [DIGITS-1:0] lz_s;
  logic              lz_sel_s;
  logic              blank_s;
  logic [6:0]        seg_s;

  // History shift register: newest capture enters entry 0, oldest falls off.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DIGITS; i++) hbuf_r[i] <= 4'h0;
    end else if (din_vld) begin
      for (int i = DIGITS - 1; i >= 1; i--) hbuf_r[i] <= hbuf_r[i-1];
      hbuf_r[0] <= din;
    end
  end

  // Count of entries written since reset, saturating at DIGITS.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fill_r <= '0;
    end else if (din_vld && (fill_r != FW'(DIGITS))) begin
      fill_r <= fill_r + FW'(1);
    end
  end

  // Scan timing: prescaler paces how long each digit stays selected.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pre_r <= '0;
      idx_r <= '0;
    end else if (pre_r == PW'(SCAN_DIV - 1)) begin
      pre_r <= '0;
      idx_r <= (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + IW'(1);
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

`ifdef SEG7_LZB_EN
  // Leading-zero mask: digit i>=1 blanks when it and everything older is zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_s     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (hbuf_r[i] == 4'h0);
      lz_s[i]  = zero_run;
    end
  end
`else
  // Leading-zero blanking disabled: zeros display as "0".
  always_comb begin
    lz_s = '0;
  end
`endif

  // Select the digit addressed by the pre-edge scan index and decode it.
  always_comb begin
    cur_s    = 4'h0;
    an_s     = '0;
    lz_sel_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      an_s[i]  = (idx_r == IW'(i));
      cur_s    = (idx_r == IW'(i)) ? hbuf_r[i] : cur_s;
      lz_sel_s = (idx_r == IW'(i)) ? lz_s[i] : lz_sel_s;
    end
    blank_s = (int'(idx_r) >= int'(fill_r)) | lz_sel_s;
    seg_s   = blank_s ? 7'h00 : dec7(cur_s);
  end

  // Registered pin drivers; full follows the pre-edge fill count.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      seg_r  <= 7'h00;
      an_r   <= '0;
      full_r <= 1'b0;
    end else begin
      seg_r  <= seg_s;
      an_r   <= an_s;
      full_r <= (fill_r == FW'(DIGITS));
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign full = full_r;

endmodule

// File: tb/tb_seg7_hex_scan.sv
// Self-checking bench for seg7_hex_scan: every edge is compared against a
// behavioural model built from a newest-first queue of captured values and
// an edge counter, plus directed scenarios and a decode vector table.
module tb_seg7_hex_scan;

  localparam int D = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         res;
  logic [3:0]   din;
  logic         din_vld;
  logic [6:0]   seg;
  logic [D-1:0] an;
  logic         full;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [3:0] hist[$];
  int         n_edges;
  int         caps;
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Per-digit observations from the last idle scan.
  logic [6:0] seen_seg [D];
  int         seen_cnt [D];

  typedef struct {
    logic [3:0] val;
    logic [6:0] exp_seg;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  seg7_hex_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .clk(clk), .res(res), .din(din), .din_vld(din_vld),
    .seg(seg), .an(an), .full(full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    n_edges = 0;
    caps    = 0;
  endtask

  // One clock edge with given inputs, checked against the model.
  task automatic step(input logic v, input logic [3:0] d);
    int         idx;
    bit         blank;
    bit         lz;
    logic [6:0] es;
    logic [D-1:0] ea;
    logic       ef;
    din_vld = v;
    din     = d;
    idx   = (n_edges / S) % D;
    blank = (idx >= hist.size());
    lz    = 1'b0;
`ifdef SEG7_LZB_EN
    if (idx >= 1) begin
      lz = 1'b1;
      for (int k = idx; k < hist.size(); k++) if (hist[k] != 4'h0) lz = 1'b0;
    end
`endif
    es = (blank || lz) ? 7'h00 : dec_tab[hist[idx]];
    ea = '0;
    ea[idx] = 1'b1;
    ef = (caps >= D);
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(es));
    check("an", 32'(an), 32'(ea));
    check("full", 32'(full), 32'(ef));
    n_edges++;
    if (v) begin
      hist.push_front(d);
      if (hist.size() > D) void'(hist.pop_back());
      caps++;
    end
  endtask

  // Reset held for three edges with a live capture strobe.
  task automatic do_reset();
    res = 1'b0; din_vld = 1'b1; din = 4'h5;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_an", 32'(an), 32'h0);
      check("rst_full", 32'(full), 32'h0);
    end
    res = 1'b1;
    model_clear();
  endtask

  // Idle for n edges, recording what each digit showed and for how long.
  task automatic idle_scan(input int n);
    for (int d = 0; d < D; d++) begin
      seen_seg[d] = 7'h7F;
      seen_cnt[d] = 0;
    end
    for (int c = 0; c < n; c++) begin
      step(1'b0, 4'h0);
      for (int d = 0; d < D; d++) begin
        if (an[d]) begin
          seen_seg[d] = seg;
          seen_cnt[d]++;
        end
      end
    end
  endtask

  initial begin
    logic [6:0] exp_lzb [D];
    bit         seen_3f;
    bit         found;
    res = 1'b0; din_vld = 1'b0; din = 4'h0;
    model_clear();
    vecs = '{'{4'h0, 7'h3F}, '{4'h1, 7'h06}, '{4'h2, 7'h5B}, '{4'h3, 7'h4F},
             '{4'h4, 7'h66}, '{4'h5, 7'h6D}, '{4'h6, 7'h7D}, '{4'h7, 7'h07},
             '{4'h8, 7'h7F}, '{4'h9, 7'h6F}, '{4'hA, 7'h77}, '{4'hB, 7'h7C},
             '{4'hC, 7'h39}, '{4'hD, 7'h5E}, '{4'hE, 7'h79}, '{4'hF, 7'h71}};
    #2;

    // Reset, then first edge: digit 0 selected and blank.
    do_reset();
    step(1'b0, 4'h0);
    check("first_an", 32'(an), 32'h1);
    check("first_seg", 32'(seg), 32'h0);

    // Basic capture 1,2,3,A then idle full scans.
    do_reset();
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3); step(1'b1, 4'hA);
    idle_scan(D * S);
    check("basic_full", 32'(full), 32'h1);
    check("basic_d0", 32'(seen_seg[0]), 32'h77);
    check("basic_d1", 32'(seen_seg[1]), 32'h4F);
    check("basic_d2", 32'(seen_seg[2]), 32'h5B);
    check("basic_d3", 32'(seen_seg[3]), 32'h06);
    for (int d = 0; d < D; d++) check("basic_hold", 32'(seen_cnt[d]), 32'(S));

    // Partial fill: single F.
    do_reset();
    step(1'b1, 4'hF);
    idle_scan(D * S);
    check("part_d0", 32'(seen_seg[0]), 32'h71);
    for (int d = 1; d < D; d++) check("part_blank", 32'(seen_seg[d]), 32'h0);
    for (int d = 0; d < D; d++) check("part_hold", 32'(seen_cnt[d]), 32'(S));
    check("part_full", 32'(full), 32'h0);

    // Counter hookup: 0..F wrapping for 20 cycles.
    do_reset();
    seen_3f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'(i % 16));
      if (i >= 16 && an[0] && seg == 7'h3F) seen_3f = 1'b1;
    end
    check("cnt_full", 32'(full), 32'h1);
    check("cnt_wrap_3f", 32'(seen_3f), 32'h1);

    // Leading-zero blanking pattern 0,0,7,0.
    do_reset();
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h7); step(1'b1, 4'h0);
    idle_scan(D * S);
`ifdef SEG7_LZB_EN
    exp_lzb = '{7'h3F, 7'h07, 7'h00, 7'h00};
`else
    exp_lzb = '{7'h3F, 7'h07, 7'h3F, 7'h3F};
`endif
    for (int d = 0; d < D; d++) check("lzb_digit", 32'(seen_seg[d]), 32'(exp_lzb[d]));

    // Decode table: capture each value, wait for digit 0, compare.
    for (int v = 0; v < 16; v++) begin
      step(1'b1, vecs[v].val);
      found = 1'b0;
      for (int c = 0; c < 2 * D * S && !found; c++) begin
        step(1'b0, 4'h0);
        if (an[0]) found = 1'b1;
      end
      check("dec_found", 32'(found), 32'h1);
      if (found) check("dec_seg", 32'(seg), 32'(vecs[v].exp_seg));
    end

    // Reset mid-scan while idx=2: outputs clear with no clock edge.
    found = 1'b0;
    for (int c = 0; c < 2 * D * S && !found; c++) begin
      if (((n_edges / S) % D) == 2) found = 1'b1;
      else step(1'b1, 4'(c));
    end
    check("mid_reach_idx2", 32'(found), 32'h1);
    step(1'b1, 4'h9);
    res = 1'b0;
    #2;
    check("mid_seg", 32'(seg), 32'h0);
    check("mid_an", 32'(an), 32'h0);
    check("mid_full", 32'(full), 32'h0);
    @(posedge clk);
    #1;
    res = 1'b1;
    model_clear();
    step(1'b0, 4'h0);
    check("mid_restart_an", 32'(an), 32'h1);
    idle_scan(D * S);
    for (int d = 0; d < D; d++) check("mid_blank", 32'(seen_seg[d]), 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        res = 1'b0;
        #2;
        check("rnd_rst_seg", 32'(seg), 32'h0);
        check("rnd_rst_an", 32'(an), 32'h0);
        @(posedge clk);
        #1;
        res = 1'b1;
        model_clear();
      end
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_hex_scan.md
# seg7_hex_scan

Downstream display stage for the 4-bit hex counter. It captures the counter's `q` value on a strobe into a short history buffer of the most recent DIGITS values, then time-multiplexes that buffer onto a common-cathode seven-segment array. Digit 0 (rightmost) shows the newest value. The block sits between the counter output and the board's segment/anode pins.

## Interface
- `DIGITS`, default 4: number of history entries and display digits; legal range 1–8.
- `SCAN_DIV`, default 4: clock cycles each digit stays selected; legal values ≥1.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `res`  in  1: reset, asynchronous and active-low.
- `din`  in  4: hex value from the counter's `q`.
- `din_vld`  in  1: capture strobe; tie high to capture every cycle.
- `seg`  out  7: segment drive {g,f,e,d,c,b,a}, active-high, registered.
- `an`  out  DIGITS: digit select, one-hot, active-high, registered.
- `full`  out  1: high once DIGITS captures have occurred since reset, registered.

## Operation
- **History buffer** `hbuf[0..DIGITS-1]`, 4 bits each.
  - On an edge with `din_vld`=1: `hbuf[i]`←`hbuf[i-1]` for i≥1, and `hbuf[0]`←`din`. The oldest entry is discarded.
- **Fill counter**, 0..DIGITS:
  - Increments on each capture.
  - Saturates at DIGITS.
  - `full` = (fill==DIGITS).
- **Prescaler** `pre`, 0..SCAN_DIV-1:
  - Increments every cycle.
  - At SCAN_DIV-1 it wraps to 0, and the scan index `idx` advances.
  - `idx` counts 0..DIGITS-1 and wraps to 0.
  - With SCAN_DIV=1, `idx` advances every cycle.
- **Output register**, loaded every cycle from the current (pre-edge) `idx` and `hbuf`:
  - `an` ← one-hot(`idx`).
  - `seg` ← decode(`hbuf[idx]`), unless the digit is blank, in which case `seg` ← 7'h00.
- **Blank rule:** digit `idx` is blank when `idx` ≥ fill, meaning that entry has not yet been written since reset.
- **Decode:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Capture and scan are independent.** A capture on the same edge as an `idx` advance is legal. The output register samples the pre-edge buffer.

## Timing
- **Reset values** (asserted asynchronously): `hbuf`=0, fill=0, `pre`=0, `idx`=0, `seg`=7'h00, `an`=0, `full`=0.
- **First edge after `res` deasserts:** `an`=one-hot(0), `seg`=7'h00 (blank).
- **Capture latency:**
  - `din` sampled at edge k lands in `hbuf[0]` at edge k.
  - It appears on `seg` at the first edge j>k at which the pre-edge `idx`=0.
  - Minimum latency is 1 cycle.
- **Scan period:** DIGITS×SCAN_DIV cycles per full refresh. Each `an` bit is high for exactly SCAN_DIV consecutive cycles.
- **`full` timing:** `full` rises at the edge after the DIGITS-th capture and stays high until reset.
- **Reset mid-operation:** all state clears immediately (asynchronously), with no partial scan completion. Scan restarts at digit 0.

## Configuration
- **`SEG7_LZB_EN`** (leading-zero blanking).
  - **Defined:** digit i≥1 is additionally blank when `hbuf[i..DIGITS-1]` are all zero. Digit 0 is never blanked by this rule; it shows "0".
  - **Undefined:** only the fill-based blank rule applies, and zeros display as "0".

## Test plan
- **Reset:** hold `res`=0 for 3 cycles with `din_vld`=1 and `din`=4'h5 → `seg`=00, `an`=0, `full`=0 throughout. After release, the first edge gives `an`=0001 and `seg`=00.
- **Basic capture (DIGITS=4, SCAN_DIV=4):** capture 1, 2, 3, A on consecutive cycles, then drop `din_vld` → `full`=1. The scan shows digit0=77 (A), digit1=4F (3), digit2=5B (2), digit3=06 (1). Each digit is held for 4 cycles, and the pattern repeats every 16 cycles.
- **Partial fill:** a single capture of F → digit0 `seg`=71. Digits 1–3 give `seg`=00 while their `an` bits still cycle.
- **Counter hookup:** drive `din` from a 0..F wrapping counter with `din_vld`=1 for 20 cycles → the buffer holds the 4 most recent values. After the count passes F, the wrap to 0 is visible in digit0 as 3F. `full` stays 1.
- **Reset mid-scan:** assert `res` while `idx`=2 → all outputs go to zero with no clock edge. After release the scan restarts at `an`=0001 and every digit is blank.
- **`SEG7_LZB_EN`:** with the macro defined, capture 0, 0, 7, 0 (oldest→newest order 0, 0, 7, 0) → digits 3 and 2 blank, digit1=07, digit0=3F. With the macro undefined, digits 3 and 2 show 3F.
